// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader family: FSM states, output FIFO sizing and lane helpers.
package weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wl_state_t;

    // Enough beats to absorb every read in flight plus a partial pack, with two beats of slack.
    function automatic int fifo_depth_beats(input int rd_lat, input int lanes);
        return (rd_lat + lanes) / lanes + 2;
    endfunction

    // Number of populated lanes in the final beat of a run of cnt weights (cnt > 0).
    function automatic int last_beat_lanes(input int cnt, input int lanes);
        return (cnt % lanes == 0) ? lanes : (cnt % lanes);
    endfunction

endpackage

// File: rtl/wsl_beat_fifo.sv
// Synchronous beat FIFO for the weight stream loader; exposes its free-slot count so the
// fetch side can issue reads only against guaranteed space.
module wsl_beat_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] free_slots
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop     = pop && (count_reg != '0);
    assign do_push    = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);
    assign head_valid = (count_reg != '0);
    // Head is forced to zero when empty so the stream outputs read as idle.
    assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
    assign free_slots = CNT_W'(DEPTH) - count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/weight_stream_loader.sv
// Streams a run of W-bit weights from the weight BRAM as packed LANES-wide valid/ready beats.
// Optional WSL_CHECKSUM_EN adds chk_sum, the sum of all weights delivered in the last run.
module weight_stream_loader
    import weight_loader_pkg::*;
#(
    parameter int W          = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int CNT_WIDTH  = 18,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  count,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [W-1:0]          bram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*W-1:0]    out_data,
    output logic [LANES-1:0]      out_keep,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef WSL_CHECKSUM_EN
    ,
    output logic [CNT_WIDTH+W-1:0] chk_sum
`endif
);

    localparam int DEPTH    = fifo_depth_beats(RD_LAT, LANES);
    localparam int FCW      = $clog2(DEPTH + 1);
    localparam int FILL_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FLIGHT_W = $clog2(RD_LAT + 1);
    localparam int BEAT_W   = LANES * W + LANES + 1;

    wl_state_t             state_reg;
    wl_state_t             state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [CNT_WIDTH-1:0]  issued_reg;
    logic [CNT_WIDTH-1:0]  recv_reg;
    logic [RD_LAT-1:0]     vpipe_reg;
    logic [FLIGHT_W-1:0]   in_flight_reg;
    logic [LANES*W-1:0]    pack_data_reg;
    logic [FILL_W-1:0]     fill_reg;

    logic                  start_ok;
    logic                  issue;
    logic                  credit_ok;
    logic [15:0]           credit_cap;
    logic [15:0]           credit_used;
    logic                  data_valid;
    logic                  last_weight;
    logic                  push_beat;
    logic [LANES*W-1:0]    merged_data;
    logic [LANES-1:0]      push_keep;
    logic [BEAT_W-1:0]     push_data;
    logic [BEAT_W-1:0]     head_data;
    logic                  head_valid;
    logic [FCW-1:0]        free_slots;
    logic                  pop;

    // A read is only issued if every weight already committed (in flight or half-packed),
    // plus this one, is guaranteed a lane in the FIFO's free space.
    assign credit_cap  = 16'(free_slots) * 16'(LANES);
    assign credit_used = 16'(in_flight_reg) + 16'(fill_reg);
    assign credit_ok   = credit_cap > credit_used;

    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if ((issued_reg != cnt_reg) && credit_ok) begin
                    issue = 1'b1;
                    if (issued_reg + 1'b1 == cnt_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_data[BEAT_W-1]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign data_valid  = vpipe_reg[RD_LAT-1];
    assign last_weight = (recv_reg + 1'b1 == cnt_reg);
    assign push_beat   = data_valid && ((fill_reg == FILL_W'(LANES - 1)) || last_weight);

    // Lanes above the fill point are already zero in the pack register, so a short final
    // beat carries zeros in its unused lanes without extra masking.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged_data[gi*W +: W] = (fill_reg == FILL_W'(gi)) ? bram_dout
                                                                       : pack_data_reg[gi*W +: W];
            assign push_keep[gi] = (FILL_W'(gi) <= fill_reg);
        end
    endgenerate

    assign push_data = {last_weight, push_keep, merged_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            cnt_reg       <= '0;
            issued_reg    <= '0;
            recv_reg      <= '0;
            vpipe_reg     <= '0;
            in_flight_reg <= '0;
            pack_data_reg <= '0;
            fill_reg      <= '0;
        end else begin
            if (start_ok) begin
                addr_reg      <= base_addr;
                cnt_reg       <= count;
                issued_reg    <= '0;
                recv_reg      <= '0;
                pack_data_reg <= '0;
                fill_reg      <= '0;
            end
            if (issue) begin
                addr_reg   <= addr_reg + 1'b1;
                issued_reg <= issued_reg + 1'b1;
            end
            vpipe_reg <= (vpipe_reg << 1) | RD_LAT'(issue);
            case ({issue, data_valid})
                2'b10:   in_flight_reg <= in_flight_reg + 1'b1;
                2'b01:   in_flight_reg <= in_flight_reg - 1'b1;
                default: in_flight_reg <= in_flight_reg;
            endcase
            if (data_valid) begin
                recv_reg <= recv_reg + 1'b1;
                if (push_beat) begin
                    pack_data_reg <= '0;
                    fill_reg      <= '0;
                end else begin
                    pack_data_reg <= merged_data;
                    fill_reg      <= fill_reg + 1'b1;
                end
            end
        end
    end

    wsl_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH),
        .CNT_W (FCW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_beat),
        .push_data  (push_data),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .free_slots (free_slots)
    );

    assign pop       = head_valid && out_ready;
    assign out_valid = head_valid;
    assign out_data  = head_data[LANES*W-1:0];
    assign out_keep  = head_data[LANES*W +: LANES];
    assign out_last  = head_data[BEAT_W-1];
    assign bram_en   = issue;
    assign bram_addr = issue ? addr_reg : '0;
    assign busy      = (state_reg == FETCH) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);

`ifdef WSL_CHECKSUM_EN
    logic [CNT_WIDTH+W-1:0] sum_reg;
    logic [CNT_WIDTH+W-1:0] beat_sum;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum = beat_sum + (CNT_WIDTH+W)'(out_data[i*W +: W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (start_ok) begin
            sum_reg <= '0;
        end else if (pop) begin
            sum_reg <= sum_reg + beat_sum;
        end
    end

    assign chk_sum = sum_reg;
`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader with a behavioural BRAM whose contents are a fixed
// function of address. Define WSL_CHECKSUM_EN to also exercise chk_sum.
module tb_weight_stream_loader;

    localparam int W          = 8;
    localparam int LANES      = 4;
    localparam int ADDR_WIDTH = 18;
    localparam int CNT_WIDTH  = 18;
    localparam int RD_LAT     = 2;
    localparam int DEPTH      = (RD_LAT + 1 + LANES - 1) / LANES + 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [W-1:0]          bram_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*W-1:0]    out_data;
    logic [LANES-1:0]      out_keep;
    logic                  out_last;
    logic                  busy;
    logic                  done;
`ifdef WSL_CHECKSUM_EN
    logic [CNT_WIDTH+W-1:0] chk_sum;
`endif

    always #5 clk = ~clk;

    weight_stream_loader #(
        .W(W), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef WSL_CHECKSUM_EN
        ,
        .chk_sum   (chk_sum)
`endif
    );

    // BRAM contents: addresses 0..7 hold 1..8; higher addresses vary with the upper byte too.
    function automatic logic [7:0] wmodel(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] v;
        v = a + 18'd1 + (a >> 8);
        return v[7:0];
    endfunction

    logic [W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= bram_en ? wmodel(bram_addr) : 8'h00;
        for (int i = 1; i < RD_LAT; i++) begin
            bram_pipe[i] <= bram_pipe[i-1];
        end
    end
    assign bram_dout = bram_pipe[RD_LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int r_beats, r_done_cnt, r_done_cyc, r_first_cyc, r_en_cnt;
    int r_stab_err, r_credit_err, r_busy_err;
    logic [63:0] r_chk_done, r_chk_c1;

    task automatic run_case(input string name, input int base, input int cnt,
                            input int ready_pct, input int abort_at);
        int cyc, issued, delivered, beat, lanes_in, post_done;
        bit fin, prev_stall;
        logic [LANES*W-1:0] prev_data, exp_data;
        logic [LANES-1:0]   prev_keep, exp_keep;
        logic               prev_last;
        logic [ADDR_WIDTH-1:0] a;
        r_beats = 0; r_done_cnt = 0; r_done_cyc = -1; r_first_cyc = -1; r_en_cnt = 0;
        r_stab_err = 0; r_credit_err = 0; r_busy_err = 0; r_chk_done = '0; r_chk_c1 = '1;
        issued = 0; delivered = 0; beat = 0; post_done = 0; prev_stall = 0;
        prev_data = '0; prev_keep = '0; prev_last = 1'b0;
        @(negedge clk);
        base_addr = ADDR_WIDTH'(base);
        count     = CNT_WIDTH'(cnt);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        fin = 0;
        while (!fin) begin
            cyc++;
            if (bram_en) begin
                a = ADDR_WIDTH'(base + issued);
                check($sformatf("%s addr%0d", name, issued), 64'(bram_addr), 64'(a));
                issued++;
                r_en_cnt++;
                if (issued - delivered > DEPTH * LANES) r_credit_err++;
            end
            if (out_valid && r_first_cyc < 0) r_first_cyc = cyc;
            if (prev_stall && (!out_valid || out_data !== prev_data || out_keep !== prev_keep
                               || out_last !== prev_last)) r_stab_err++;
            if (busy !== ((cnt > 0) && (r_done_cnt == 0) && !done)) r_busy_err++;
`ifdef WSL_CHECKSUM_EN
            if (cyc == 1) r_chk_c1 = 64'(chk_sum);
            if (done) r_chk_done = 64'(chk_sum);
`endif
            if (done) begin
                r_done_cnt++;
                r_done_cyc = cyc;
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) begin
                lanes_in = cnt - beat * LANES;
                if (lanes_in > LANES) lanes_in = LANES;
                exp_keep = '0;
                exp_data = '0;
                for (int l = 0; l < lanes_in; l++) begin
                    exp_keep[l] = 1'b1;
                    a = ADDR_WIDTH'(base + beat * LANES + l);
                    exp_data[l*W +: W] = wmodel(a);
                end
                check($sformatf("%s data%0d", name, beat), 64'(out_data), 64'(exp_data));
                check($sformatf("%s keep%0d", name, beat), 64'(out_keep), 64'(exp_keep));
                check($sformatf("%s last%0d", name, beat), 64'(out_last),
                      64'(beat * LANES + lanes_in == cnt));
                delivered += lanes_in;
                beat++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_keep  = out_keep;
            prev_last  = out_last;
            // Poke start while busy and in the DONE cycle; both must be ignored.
            start = (done === 1'b1) || (cnt > 0 && cyc == 3);
            if (start) base_addr = ADDR_WIDTH'(base + 100);
            if (r_done_cnt > 0) post_done++;
            if (post_done >= 4 || cyc >= 20000 || (abort_at > 0 && cyc == abort_at)) fin = 1;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        r_beats = beat;
        $display("%s: base=%0d count=%0d beats=%0d first_valid=%0d done_cyc=%0d reads=%0d",
                 name, base, cnt, r_beats, r_first_cyc, r_done_cyc, r_en_cnt);
    endtask

    task automatic run_checks(input string name, input int cnt, input int exp_done_cyc);
        check({name, " beats"}, 64'(r_beats), 64'((cnt + LANES - 1) / LANES));
        check({name, " done_cnt"}, 64'(r_done_cnt), 64'd1);
        check({name, " reads"}, 64'(r_en_cnt), 64'(cnt));
        check({name, " first_valid"}, 64'(r_first_cyc),
              (cnt == 0) ? 64'(-1) : 64'(RD_LAT + LANES + 1));
        check({name, " stable"}, 64'(r_stab_err), 64'd0);
        check({name, " credit"}, 64'(r_credit_err), 64'd0);
        check({name, " busy"}, 64'(r_busy_err), 64'd0);
        if (exp_done_cyc >= 0) check({name, " done_cyc"}, 64'(r_done_cyc), 64'(exp_done_cyc));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " bram_en"},   64'(bram_en),   64'd0);
        check({name, " bram_addr"}, 64'(bram_addr), 64'd0);
        check({name, " out_valid"}, 64'(out_valid), 64'd0);
        check({name, " out_data"},  64'(out_data),  64'd0);
        check({name, " out_keep"},  64'(out_keep),  64'd0);
        check({name, " out_last"},  64'(out_last),  64'd0);
        check({name, " busy"},      64'(busy),      64'd0);
        check({name, " done"},      64'(done),      64'd0);
    endtask

    int quiet_err;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_case("t1_long", 147584, 1280, 100, 0);
        run_checks("t1_long", 1280, 1280 + RD_LAT + 2);

        run_case("t2_partial", 64, 10, 100, 0);
        run_checks("t2_partial", 10, 10 + RD_LAT + 2);

        run_case("t3_backpressure", 3000, 517, 30, 0);
        run_checks("t3_backpressure", 517, -1);

        run_case("t4_zero", 500, 0, 100, 0);
        run_checks("t4_zero", 0, 1);

        run_case("t_wrap", 262142, 5, 100, 0);
        run_checks("t_wrap", 5, 5 + RD_LAT + 2);

        run_case("t5_abort", 9000, 1000, 100, 20);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("t5_after_rst");
        rst = 1'b0;
        quiet_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || out_valid || busy || bram_en) quiet_err++;
        end
        check("t5 quiet_after_abort", 64'(quiet_err), 64'd0);
        run_case("t5_restart", 40, 8, 100, 0);
        run_checks("t5_restart", 8, 8 + RD_LAT + 2);

`ifdef WSL_CHECKSUM_EN
        run_case("t6_sum", 0, 8, 100, 0);
        run_checks("t6_sum", 8, 8 + RD_LAT + 2);
        check("t6 chk_sum_done", r_chk_done, 64'd36);
        run_case("t6_sum2", 0, 8, 100, 0);
        check("t6 chk_sum_cleared", r_chk_c1, 64'd0);
        check("t6 chk_sum_done2", r_chk_done, 64'd36);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
